// File: rtl/imem_arb_pkg.sv
// Shared definitions for the instruction-memory arbiter.
//   owner_e  : which requester won the ROM port in the previous cycle
//   WORD_LSB : number of byte-offset bits dropped by the word-addressed ROM
package imem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_IF   = 2'b01,
    OWN_DBG  = 2'b10
  } owner_e;

  localparam int WORD_LSB = 2;

  // True when a byte address does not sit on a word boundary.
  function automatic logic is_misaligned(input logic [WORD_LSB-1:0] byte_off);
    return |byte_off;
  endfunction

endpackage

// File: rtl/imem_arbiter.sv
// imem_arbiter
// Shares the combinational read port of the instruction ROM between the IF
// stage (primary) and the debug/test-dump reader (secondary). The ROM output is
// registered, so every grant yields a response exactly one cycle later.
// IF has priority; a saturating starvation counter forces a debug grant after
// STARVE_MAX-1 consecutive denied debug cycles.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   if_req/if_addr    IF read request and byte address
//   if_flush          blocks a new IF grant in this cycle
//   if_gnt            IF request accepted (combinational)
//   if_rvalid/rdata   IF response (registered)
//   if_misalign       granted IF address was not word aligned (registered)
//   dbg_req/dbg_addr  debug read request; held stable until dbg_gnt
//   dbg_gnt           debug request accepted (combinational)
//   dbg_rvalid/rdata  debug response (registered)
//   mem_raddr         address to the ROM, 0 when nothing is granted
//   mem_rdata         combinational read data from the ROM
module imem_arbiter
  import imem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 32,
  parameter int STARVE_MAX = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  input  logic                  if_flush,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [DATA_WIDTH-1:0] if_rdata,
  output logic                  if_misalign,
  input  logic                  dbg_req,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  output logic                  dbg_gnt,
  output logic                  dbg_rvalid,
  output logic [DATA_WIDTH-1:0] dbg_rdata,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int CNT_W = (STARVE_MAX > 2) ? $clog2(STARVE_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX - 1);

  owner_e           owner;
  owner_e           owner_next;
  logic [CNT_W-1:0] starve_cnt;
  logic [CNT_W-1:0] starve_cnt_next;
  logic             if_ok;
  logic             dbg_live;
  logic             force_dbg;

  // Arbitration and next-state. Requests are qualified with rst_n so that no
  // grant (and no ROM address) escapes while the block is held in reset.
  always_comb begin
    if_ok           = if_req & ~if_flush & rst_n;
    dbg_live        = dbg_req & rst_n;
    force_dbg       = dbg_live & (starve_cnt == CNT_MAX);
    dbg_gnt         = dbg_live & (~if_ok | force_dbg);
    if_gnt          = if_ok & ~dbg_gnt;

    mem_raddr       = '0;
    if (if_gnt) begin
      mem_raddr = if_addr;
    end else if (dbg_gnt) begin
      mem_raddr = dbg_addr;
    end

    // Owner records this cycle's winner; it becomes the response-valid state.
    owner_next      = OWN_NONE;
    case (owner)
      OWN_NONE, OWN_IF, OWN_DBG: begin
        if (dbg_gnt) begin
          owner_next = OWN_DBG;
        end else if (if_gnt) begin
          owner_next = OWN_IF;
        end
      end
      default: owner_next = OWN_NONE;
    endcase

    // Count consecutive denied debug cycles; any grant or idle cycle clears it.
    starve_cnt_next = '0;
    if (dbg_live && !dbg_gnt) begin
      starve_cnt_next = (starve_cnt == CNT_MAX) ? CNT_MAX : starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner      <= OWN_NONE;
      starve_cnt <= '0;
    end else begin
      owner      <= owner_next;
      starve_cnt <= starve_cnt_next;
    end
  end

  // Response data: only the winner's word register loads; the loser keeps its
  // last value. Misalignment is flagged only alongside an IF response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_rdata    <= '0;
      dbg_rdata   <= '0;
      if_misalign <= 1'b0;
    end else begin
      if_misalign <= 1'b0;
      case (owner_next)
        OWN_IF: begin
          if_rdata    <= mem_rdata;
          if_misalign <= is_misaligned(if_addr[WORD_LSB-1:0]);
        end
        OWN_DBG: dbg_rdata <= mem_rdata;
        default: ;
      endcase
    end
  end

  // The owner register doubles as the response-valid flags.
  assign if_rvalid  = (owner == OWN_IF);
  assign dbg_rvalid = (owner == OWN_DBG);

  a_one_grant : assert property (@(posedge clk) disable iff (!rst_n)
    !(if_gnt && dbg_gnt));

  a_one_rvalid : assert property (@(posedge clk) disable iff (!rst_n)
    !(if_rvalid && dbg_rvalid));

  a_idle_addr : assert property (@(posedge clk) disable iff (!rst_n)
    (!if_gnt && !dbg_gnt) |-> (mem_raddr == '0));

endmodule
